// File: rtl/axis_rr_pkt_arbiter_if.sv
// Bundle of the source-side and merged-output AXI-Stream signals of the
// round-robin packet arbiter.
//   s_valid/s_data/s_keep/s_last : NUM_SRC sources, lane i at [i*W +: W]
//   s_ready                      : per-source ready back to the sources
//   m_valid/m_data/m_keep/m_last : merged registered output stream
//   m_src                        : index of the source that produced m_data
//   m_ready                      : downstream ready
// Modports: slave = the arbiter, master = the environment around it.
interface axis_rr_pkt_arbiter_if #(
  parameter int NUM_SRC         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int SRC_WD          = $clog2(NUM_SRC)
) ();
  logic [NUM_SRC-1:0]                 s_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0]      s_data;
  logic [NUM_SRC*DATA_BYTE_WIDTH-1:0] s_keep;
  logic [NUM_SRC-1:0]                 s_last;
  logic [NUM_SRC-1:0]                 s_ready;
  logic                               m_valid;
  logic [DATA_WIDTH-1:0]              m_data;
  logic [DATA_BYTE_WIDTH-1:0]         m_keep;
  logic                               m_last;
  logic [SRC_WD-1:0]                  m_src;
  logic                               m_ready;

  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last, m_src
  );

  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last, m_src
  );
endinterface

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI-Stream output slice
// between NUM_SRC sources. A grant is held from the first accepted beat of
// a packet through its last beat, so packets never interleave.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : source and output stream signals (slave modport)
//   busy  : high while a grant is held
module axis_rr_pkt_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int SRC_WD          = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_rr_pkt_arbiter_if.slave bus,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [SRC_WD-1:0] PTR_RST = SRC_WD'(NUM_SRC - 1);

  state_t                     state_q, state_d;
  logic [SRC_WD-1:0]          gnt_q, gnt_d;
  logic [SRC_WD-1:0]          ptr_q, ptr_d;
  logic                       m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]      m_data_q, m_data_d;
  logic [DATA_BYTE_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                       m_last_q, m_last_d;
  logic [SRC_WD-1:0]          m_src_q, m_src_d;

  logic [SRC_WD-1:0]          pick;
  logic                       rr_found;
  int unsigned                rr_idx;
  logic [SRC_WD-1:0]          rr_cand;

  logic                       sel_valid;
  logic                       sel_last;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [DATA_BYTE_WIDTH-1:0] sel_keep;
  logic                       slot_free;
  logic                       accept;
  logic [NUM_SRC-1:0]         s_ready;

  // Search upward from ptr+1; the modulo keeps the wrap at NUM_SRC even when
  // NUM_SRC is not a power of two.
  always_comb begin
    pick     = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      rr_idx  = (32'(ptr_q) + i) % NUM_SRC;
      rr_cand = rr_idx[SRC_WD-1:0];
      if (!rr_found && bus.s_valid[rr_cand]) begin
        pick     = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Lanes of the granted source.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt_q == SRC_WD'(i)) begin
        sel_valid = bus.s_valid[i];
        sel_last  = bus.s_last[i];
        sel_data  = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = bus.s_keep[i*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
      end
    end
  end

  assign slot_free = !m_valid_q || bus.m_ready;
  assign accept    = (state_q == BUSY) && sel_valid && slot_free;

  always_comb begin
    s_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      s_ready[i] = (state_q == BUSY) && (gnt_q == SRC_WD'(i)) && slot_free;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.s_valid) begin
          state_d = BUSY;
          gnt_d   = pick;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          ptr_d   = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new beat overwrites a beat being drained in the same cycle.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_src_d   = m_src_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_keep_d  = sel_keep;
      m_last_d  = sel_last;
      m_src_d   = gnt_q;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= PTR_RST;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_src_q   <= m_src_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_src   = m_src_q;
  assign busy        = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Self-checking bench for axis_rr_pkt_arbiter: per-source packet queues feed
// the sources, a behavioural arbitration model predicts ready/busy/valid and
// pushes expected beats into a scoreboard that is drained as the output
// stream hands beats downstream.
module tb_axis_rr_pkt_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  axis_rr_pkt_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  axis_rr_pkt_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  beat_t         src_q [NS][$];
  exp_t          sb_q [$];
  logic [NS-1:0] hold;
  logic [NS-1:0] acc_vec = '0;

  int n_checks;
  int n_fail;

  // arbitration model
  logic          mdl_busy = 1'b0;
  logic          mdl_mv   = 1'b0;
  logic [SW-1:0] mdl_gnt  = '0;
  logic [SW-1:0] mdl_ptr  = SW'(NS - 1);
  logic [NS-1:0] exp_rdy;
  logic          acc_m;
  exp_t          e_new;
  exp_t          e_got;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;
  logic [SW-1:0] prev_src;

  int            cyc = 0;
  int            busy_cyc;
  int            mv_cyc;
  int            last_end_cyc;
  logic          in_pkt = 1'b0;
  int            src_log [$];
  int            gap_log [$];
  logic [DW-1:0] data_log [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rotate the request vector so ptr+1 sits at bit 0, then take the lowest set bit.
  function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] ptr, input logic [NS-1:0] req);
    logic [2*NS-1:0] dbl;
    logic [NS-1:0]   rot;
    int              r;
    dbl = {req, req};
    rot = dbl[int'(ptr) + 1 +: NS];
    r = 0;
    for (int k = NS - 1; k >= 0; k--) if (rot[k]) r = k;
    return SW'((int'(ptr) + 1 + r) % NS);
  endfunction

  function automatic int src_at(input int k);
    return (k < src_log.size()) ? src_log[k] : -1;
  endfunction

  function automatic logic [DW-1:0] data_at(input int k);
    return (k < data_log.size()) ? data_log[k] : '1;
  endfunction

  function automatic logic all_idle();
    logic e;
    e = (sb_q.size() == 0) && !mdl_busy && !mdl_mv;
    for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) e = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_busy   = 1'b0;
      mdl_mv     = 1'b0;
      mdl_gnt    = '0;
      mdl_ptr    = SW'(NS - 1);
      acc_vec    = '0;
      prev_stall = 1'b0;
      in_pkt     = 1'b0;
    end else begin
      exp_rdy = '0;
      if (mdl_busy && (!mdl_mv || bus.m_ready)) exp_rdy[mdl_gnt] = 1'b1;
      chk("s_ready", 64'(bus.s_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(mdl_busy));
      chk("m_valid", 64'(bus.m_valid), 64'(mdl_mv));
      if (prev_stall) begin
        chk("stall_data", 64'(bus.m_data), 64'(prev_data));
        chk("stall_keep", 64'(bus.m_keep), 64'(prev_keep));
        chk("stall_last", 64'(bus.m_last), 64'(prev_last));
        chk("stall_src", 64'(bus.m_src), 64'(prev_src));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_keep  = bus.m_keep;
      prev_last  = bus.m_last;
      prev_src   = bus.m_src;
      busy_cyc   += int'(busy);
      mv_cyc     += int'(bus.m_valid);

      if (mdl_mv && bus.m_ready) begin
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          e_got = sb_q.pop_front();
          chk("out_src", 64'(bus.m_src), 64'(e_got.src));
          chk("out_data", 64'(bus.m_data), 64'(e_got.data));
          chk("out_keep", 64'(bus.m_keep), 64'(e_got.keep));
          chk("out_last", 64'(bus.m_last), 64'(e_got.last));
        end
        data_log.push_back(bus.m_data);
        if (!in_pkt && last_end_cyc >= 0) gap_log.push_back(cyc - last_end_cyc);
        if (bus.m_last) begin
          src_log.push_back(int'(bus.m_src));
          last_end_cyc = cyc;
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end

      acc_vec = bus.s_valid & bus.s_ready;
      acc_m   = mdl_busy && bus.s_valid[mdl_gnt] && exp_rdy[mdl_gnt];
      if (acc_m) begin
        e_new.src  = mdl_gnt;
        e_new.data = DW'(bus.s_data >> (int'(mdl_gnt) * DW));
        e_new.keep = KW'(bus.s_keep >> (int'(mdl_gnt) * KW));
        e_new.last = bus.s_last[mdl_gnt];
        sb_q.push_back(e_new);
      end
      if (!mdl_busy) begin
        if (|bus.s_valid) begin
          mdl_busy = 1'b1;
          mdl_gnt  = rr_next(mdl_ptr, bus.s_valid);
        end
      end else if (acc_m && bus.s_last[mdl_gnt]) begin
        mdl_busy = 1'b0;
        mdl_ptr  = mdl_gnt;
      end
      if (acc_m) mdl_mv = 1'b1;
      else if (mdl_mv && bus.m_ready) mdl_mv = 1'b0;
    end
    cyc++;
  end

  task automatic drive();
    logic [NS-1:0]    v;
    logic [NS-1:0]    l;
    logic [NS*DW-1:0] d;
    logic [NS*KW-1:0] k;
    v = '0; l = '0; d = '0; k = '0;
    for (int s = 0; s < NS; s++) begin
      if (src_q[s].size() != 0) begin
        v[s]           = !hold[s];
        l[s]           = src_q[s][0].last;
        d[s*DW +: DW]  = src_q[s][0].data;
        k[s*KW +: KW]  = src_q[s][0].keep;
      end
    end
    bus.s_valid = v;
    bus.s_last  = l;
    bus.s_data  = d;
    bus.s_keep  = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) if (acc_vec[s] && src_q[s].size() != 0) void'(src_q[s].pop_front());
    drive();
  endtask

  task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.keep = '1;
      b.last = (i == n - 1);
      src_q[s].push_back(b);
    end
    drive();
  endtask

  task automatic run_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_idle() && n < max_cyc);
    chk({tag, "_drained"}, 64'(all_idle()), 64'(1));
  endtask

  task automatic clear_logs();
    src_log.delete();
    gap_log.delete();
    data_log.delete();
    busy_cyc     = 0;
    mv_cyc       = 0;
    last_end_cyc = -1;
  endtask

  task automatic flush();
    for (int s = 0; s < NS; s++) src_q[s].delete();
    sb_q.delete();
    drive();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'(0));
    chk({tag, "_m_data"}, 64'(bus.m_data), 64'(0));
    chk({tag, "_m_keep"}, 64'(bus.m_keep), 64'(0));
    chk({tag, "_m_last"}, 64'(bus.m_last), 64'(0));
    chk({tag, "_m_src"}, 64'(bus.m_src), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    flush();
    step();
    step();
    rst_n = 1'b1;
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    hold        = '0;
    bus.m_ready = 1'b1;
    rst_n       = 1'b0;
    clear_logs();
    drive();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;

    // single source, 3-beat packet from source 2
    clear_logs();
    push_pkt(2, 3, 32'hA0);
    run_idle("t1", 50);
    chk("t1_busy_cycles", 64'(busy_cyc), 64'(3));
    chk("t1_mvalid_cycles", 64'(mv_cyc), 64'(3));
    chk("t1_beats", 64'(data_log.size()), 64'(3));
    for (int k = 0; k < 3; k++) chk("t1_data", 64'(data_at(k)), 64'(32'hA0 + k));
    chk("t1_src", 64'(src_at(0)), 64'(2));

    // round-robin fairness, all sources offer two 2-beat packets
    do_reset();
    clear_logs();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++) push_pkt(s, 2, DW'(s * 'h100 + p * 'h10));
    run_idle("t2", 200);
    for (int k = 0; k < 8; k++) chk("t2_order", 64'(src_at(k)), 64'(exp_order[k]));
    chk("t2_gap_count", 64'(gap_log.size()), 64'(7));
    foreach (gap_log[k]) chk("t2_gap", 64'(gap_log[k]), 64'(2));

    // backpressure mid-packet
    clear_logs();
    push_pkt(1, 6, 32'hB0);
    repeat (4) step();
    bus.m_ready = 1'b0;
    repeat (5) begin
      step();
      chk("t3_sready_stall", 64'(bus.s_ready), 64'(0));
    end
    bus.m_ready = 1'b1;
    run_idle("t3", 50);
    chk("t3_beats", 64'(data_log.size()), 64'(6));
    for (int k = 0; k < 6; k++) chk("t3_data", 64'(data_at(k)), 64'(32'hB0 + k));

    // granted source 1 stalls while source 3 requests
    do_reset();
    clear_logs();
    push_pkt(1, 4, 32'hC0);
    repeat (3) step();
    hold[1] = 1'b1;
    push_pkt(3, 2, 32'hD0);
    repeat (4) begin
      step();
      chk("t4_src3_ready", 64'(bus.s_ready[3]), 64'(0));
      chk("t4_busy", 64'(busy), 64'(1));
    end
    hold[1] = 1'b0;
    drive();
    run_idle("t4", 50);
    chk("t4_first", 64'(src_at(0)), 64'(1));
    chk("t4_second", 64'(src_at(1)), 64'(3));
    chk("t4_d0_after", 64'(data_at(4)), 64'(32'hD0));

    // back-to-back single-beat packets from sources 0 and 1
    do_reset();
    clear_logs();
    push_pkt(0, 1, 32'hE0);
    push_pkt(1, 1, 32'hE1);
    run_idle("t5", 30);
    chk("t5_first", 64'(src_at(0)), 64'(0));
    chk("t5_second", 64'(src_at(1)), 64'(1));
    chk("t5_beats", 64'(data_log.size()), 64'(2));
    chk("t5_busy_cycles", 64'(busy_cyc), 64'(2));
    chk("t5_gap", 64'((gap_log.size() > 0) ? gap_log[0] : -1), 64'(2));

    // reset during beat 2 of 4 (ptr is 1 here, so source 2 is granted)
    clear_logs();
    push_pkt(2, 4, 32'hF0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    flush();
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
    push_pkt(2, 1, 32'hF8);
    push_pkt(0, 1, 32'hF9);
    run_idle("t6", 30);
    chk("t6_first", 64'(src_at(0)), 64'(0));
    chk("t6_second", 64'(src_at(1)), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
